// File: rtl/wb_sig_bank.sv
// Wishbone-classic register bank: drives the 32-bit breakout control bus and
// captures synchronized status inputs with sticky rising-edge flags and a level irq.
module wb_sig_bank #(
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] PULSE_MASK  = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [31:0] o_bus,
  input  logic [31:0] i_sig,
  output logic        o_irq
);

  localparam logic [31:0] OUT_RST = RESET_VALUE & ~PULSE_MASK;

  logic                        req, wr, rd;
  logic [31:0]                 bmask, wdat;
  logic [SYNC_STAGES-1:0][31:0] sig_sync_p;
  logic [31:0]                 sig_prev_p;
  logic [31:0]                 synced, rise;
  logic [31:0]                 edg_r, ien_r;
  logic [31:0]                 out_nxt, edg_nxt, ien_nxt, rdata;

  assign req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr     = req & i_wb_we;
  assign rd     = req & ~i_wb_we;
  assign bmask  = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign wdat   = i_wb_dat & bmask;
  assign synced = sig_sync_p[SYNC_STAGES-1];
  assign rise   = synced & ~sig_prev_p;

  // Writes apply on top of the self-cleared value, so a pulse bit never lingers
  // and a same-cycle SET/CLR simply yields the write result.
  always_comb begin
    out_nxt = o_bus & ~PULSE_MASK;
    edg_nxt = edg_r;
    ien_nxt = ien_r;
    if (wr) begin
      case (i_wb_adr)
        3'd0:    out_nxt = (out_nxt & ~bmask) | wdat;
        3'd1:    out_nxt = out_nxt | wdat;
        3'd2:    out_nxt = out_nxt & ~wdat;
        3'd4:    edg_nxt = edg_r & ~wdat;
        3'd5:    ien_nxt = (ien_r & ~bmask) | wdat;
        default: ;
      endcase
    end
    // A new edge overrides a simultaneous clear.
    edg_nxt = edg_nxt | rise;
  end

  always_comb begin
    rdata = 32'h0;
    case (i_wb_adr)
      3'd0, 3'd1, 3'd2: rdata = o_bus;
      3'd3:             rdata = synced;
      3'd4:             rdata = edg_r;
      3'd5:             rdata = ien_r;
      default:          rdata = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack   <= 1'b0;
      o_wb_dat   <= 32'h0;
      o_bus      <= OUT_RST;
      edg_r      <= 32'h0;
      ien_r      <= 32'h0;
      sig_sync_p <= '0;
      sig_prev_p <= 32'h0;
      o_irq      <= 1'b0;
    end else begin
      o_wb_ack      <= req;
      o_wb_dat      <= rd ? rdata : 32'h0;
      o_bus         <= out_nxt;
      edg_r         <= edg_nxt;
      ien_r         <= ien_nxt;
      sig_sync_p[0] <= i_sig;
      for (int k = 1; k < SYNC_STAGES; k++) sig_sync_p[k] <= sig_sync_p[k-1];
      sig_prev_p    <= synced;
      o_irq         <= |(edg_r & ien_r);
    end
  end

endmodule

// File: tb/tb_wb_sig_bank.sv
// Self-checking bench for wb_sig_bank: directed scenarios plus randomized
// register and status traffic checked against a register-level model.
module tb_wb_sig_bank;

  localparam logic [31:0] RV = 32'hA5A5_0F0F;
  localparam logic [31:0] PM = 32'h0000_0001;
  localparam int          SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;
  logic [31:0] bus;
  logic [31:0] sig;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // captured by wb_xfer: at the ack edge and one edge later
  logic        x_ack, x2_ack, x_irq, x2_irq;
  logic [31:0] x_dat, x_bus, x2_bus;

  // register-level reference state
  logic [31:0] m_out, m_edg, m_ien, m_sig;

  wb_sig_bank #(.RESET_VALUE(RV), .PULSE_MASK(PM), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .o_wb_dat(rdat),
    .o_wb_ack(ack), .o_bus(bus), .i_sig(sig), .o_irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bytes_of(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Called #1 after a rising edge with ack low; returns #1 after the edge following the ack.
  task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    @(posedge clk); #1;
    x_ack = ack; x_dat = rdat; x_bus = bus; x_irq = irq;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    x2_ack = ack; x2_bus = bus; x2_irq = irq;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0; sig = 32'h0;
    do_reset(3);
    n_tests++; if (bus !== 32'hA5A5_0F0E) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", bus, 32'hA5A5_0F0E); end
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_tests++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", rdat); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0) begin n_fail++; $display("FAIL reset_edge: got %h expected 0", x_dat); end
    wb_xfer(3'd5, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0) begin n_fail++; $display("FAIL reset_ien: got %h expected 0", x_dat); end
    wb_xfer(3'd0, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'hA5A5_0F0E) begin n_fail++; $display("FAIL reset_out_rd: got %h expected %h", x_dat, 32'hA5A5_0F0E); end
  endtask

  task automatic test_rw;
    wb_xfer(3'd0, 1'b1, 32'h0, 4'hF);
    wb_xfer(3'd0, 1'b1, 32'h1234_5678, 4'b0101);
    n_tests++; if (x_ack !== 1'b1 || x2_ack !== 1'b0) begin n_fail++; $display("FAIL rw_ack_out: got %b%b expected 10", x_ack, x2_ack); end
    n_tests++; if (x_bus !== 32'h0034_0078) begin n_fail++; $display("FAIL rw_bus_sel: got %h expected %h", x_bus, 32'h0034_0078); end
    wb_xfer(3'd1, 1'b1, 32'h8000_0000, 4'hF);
    n_tests++; if (x_ack !== 1'b1 || x2_ack !== 1'b0) begin n_fail++; $display("FAIL rw_ack_set: got %b%b expected 10", x_ack, x2_ack); end
    wb_xfer(3'd2, 1'b1, 32'h0000_0078, 4'hF);
    n_tests++; if (x_ack !== 1'b1 || x2_ack !== 1'b0) begin n_fail++; $display("FAIL rw_ack_clr: got %b%b expected 10", x_ack, x2_ack); end
    wb_xfer(3'd0, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h8034_0000) begin n_fail++; $display("FAIL rw_readback: got %h expected %h", x_dat, 32'h8034_0000); end
    n_tests++; if (x2_ack !== 1'b0 || rdat !== 32'h0) begin n_fail++; $display("FAIL rw_dat_idle: got %h expected 0", rdat); end
  endtask

  task automatic test_pulse;
    wb_xfer(3'd0, 1'b1, 32'h0000_F000, 4'hF);
    wb_xfer(3'd1, 1'b1, 32'h0000_0001, 4'hF);
    n_tests++; if (x_bus !== 32'h0000_F001) begin n_fail++; $display("FAIL pulse_high: got %h expected %h", x_bus, 32'h0000_F001); end
    n_tests++; if (x2_bus !== 32'h0000_F000) begin n_fail++; $display("FAIL pulse_clear: got %h expected %h", x2_bus, 32'h0000_F000); end
    @(posedge clk); #1;
    n_tests++; if (bus !== 32'h0000_F000) begin n_fail++; $display("FAIL pulse_stay: got %h expected %h", bus, 32'h0000_F000); end
  endtask

  task automatic test_edge_irq;
    wb_xfer(3'd5, 1'b1, 32'h0000_0080, 4'hF);
    sig = 32'h0000_0080;
    @(posedge clk); @(posedge clk); #1;
    wb_xfer(3'd3, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0000_0080) begin n_fail++; $display("FAIL edge_in_latency: got %h expected %h", x_dat, 32'h80); end
    n_tests++; if (x_irq !== 1'b0 || x2_irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_timing: got %b%b expected 01", x_irq, x2_irq); end
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0000_0080) begin n_fail++; $display("FAIL edge_flag: got %h expected %h", x_dat, 32'h80); end
    wb_xfer(3'd4, 1'b1, 32'h0000_0080, 4'hF);
    n_tests++; if (x_irq !== 1'b1 || x2_irq !== 1'b0) begin n_fail++; $display("FAIL edge_w1c_irq: got %b%b expected 10", x_irq, x2_irq); end
  endtask

  task automatic test_collision;
    sig = 32'h0000_0088;
    @(posedge clk); @(posedge clk); #1;
    wb_xfer(3'd4, 1'b1, 32'h0000_0008, 4'hF);
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0000_0008) begin n_fail++; $display("FAIL collide_set_wins: got %h expected %h", x_dat, 32'h8); end
    wb_xfer(3'd4, 1'b1, 32'h0000_0008, 4'hF);
    wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);
    n_tests++; if (x_dat !== 32'h0) begin n_fail++; $display("FAIL collide_w1c_later: got %h expected 0", x_dat); end
  endtask

  task automatic test_back_to_back;
    int acks;
    acks = 0;
    cyc = 1; stb = 1; we = 0; adr = 3'd6; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      n_tests++; if (ack !== ((i % 2) == 0)) begin n_fail++; $display("FAIL b2b_ack_%0d: got %b expected %b", i, ack, (i % 2) == 0); end
      n_tests++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL b2b_dat_%0d: got %h expected 0", i, rdat); end
    end
    cyc = 0; stb = 0;
    n_tests++; if (acks != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", acks); end
    @(posedge clk); #1;
    cyc = 0; stb = 1; we = 1; adr = 3'd0; wdat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0 || bus !== 32'h0000_F000) begin n_fail++; $display("FAIL cyc_drop: got ack %b bus %h expected 0 %h", ack, bus, 32'h0000_F000); end
    stb = 0; we = 0;
  endtask

  task automatic test_reset_mid;
    cyc = 1; stb = 1; we = 1; adr = 3'd0; wdat = 32'h1234_5678; sel = 4'hF; rst = 1;
    @(posedge clk); #1;
    n_tests++; if (bus !== 32'hA5A5_0F0E || ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got ack %b bus %h expected 0 %h", ack, bus, 32'hA5A5_0F0E); end
    rst = 0; cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    n_tests++; if (bus !== 32'hA5A5_0F0E || ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got ack %b bus %h expected 0 %h", ack, bus, 32'hA5A5_0F0E); end
  endtask

  task automatic test_random_regs;
    logic [2:0]  a;
    logic        w;
    logic [31:0] d, m, r, exp_dat;
    logic [3:0]  s;
    sig = $urandom;
    do_reset(3);
    repeat (4) @(posedge clk);
    #1;
    m_out = RV & ~PM; m_ien = 32'h0; m_sig = sig; m_edg = sig;
    for (int i = 0; i < 60; i++) begin
      a = 3'($urandom_range(0, 7)); w = 1'($urandom); d = $urandom; s = 4'($urandom);
      if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
      m = bytes_of(s) & d;
      wb_xfer(a, w, d, s);
      n_tests++; if (x_ack !== 1'b1 || x2_ack !== 1'b0) begin n_fail++; $display("FAIL rnd_ack_%0d: got %b%b expected 10", i, x_ack, x2_ack); end
      if (w) begin
        r = m_out;
        case (a)
          3'd0: r = (m_out & ~bytes_of(s)) | m;
          3'd1: r = m_out | m;
          3'd2: r = m_out & ~m;
          3'd4: m_edg = m_edg & ~m;
          3'd5: m_ien = (m_ien & ~bytes_of(s)) | m;
          default: ;
        endcase
        m_out = r & ~PM;
        n_tests++; if (x_bus !== r || x2_bus !== m_out) begin n_fail++; $display("FAIL rnd_wr_%0d a%0d: got %h/%h expected %h/%h", i, a, x_bus, x2_bus, r, m_out); end
      end else begin
        case (a)
          3'd0, 3'd1, 3'd2: exp_dat = m_out;
          3'd3: exp_dat = m_sig;
          3'd4: exp_dat = m_edg;
          3'd5: exp_dat = m_ien;
          default: exp_dat = 32'h0;
        endcase
        n_tests++; if (x_dat !== exp_dat) begin n_fail++; $display("FAIL rnd_rd_%0d a%0d: got %h expected %h", i, a, x_dat, exp_dat); end
      end
    end
  endtask

  task automatic test_random_edges;
    logic [31:0] nsig, mask;
    for (int i = 0; i < 12; i++) begin
      nsig = $urandom;
      sig = nsig;
      repeat (4) @(posedge clk);
      #1;
      m_edg = m_edg | (nsig & ~m_sig);
      m_sig = nsig;
      wb_xfer(3'd3, 1'b0, 32'h0, 4'hF);
      n_tests++; if (x_dat !== m_sig) begin n_fail++; $display("FAIL redge_in_%0d: got %h expected %h", i, x_dat, m_sig); end
      wb_xfer(3'd4, 1'b0, 32'h0, 4'hF);
      n_tests++; if (x_dat !== m_edg) begin n_fail++; $display("FAIL redge_flag_%0d: got %h expected %h", i, x_dat, m_edg); end
      if ($urandom_range(0, 1) == 1) begin
        mask = $urandom;
        wb_xfer(3'd4, 1'b1, mask, 4'hF);
        m_edg = m_edg & ~mask;
      end
      if ($urandom_range(0, 2) == 0) begin
        mask = $urandom & $urandom;
        wb_xfer(3'd5, 1'b1, mask, 4'hF);
        m_ien = mask;
      end
      @(posedge clk); #1;
      n_tests++; if (irq !== |(m_edg & m_ien)) begin n_fail++; $display("FAIL redge_irq_%0d: got %b expected %b", i, irq, |(m_edg & m_ien)); end
    end
  endtask

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0; sig = 0;
    test_reset;
    test_rw;
    test_pulse;
    test_edge_irq;
    test_collision;
    test_back_to_back;
    test_reset_mid;
    test_random_regs;
    test_random_edges;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_sig_bank.md
# wb_sig_bank

Wishbone-classic slave register bank that generates the 32-bit control bus sliced by the downstream signal-breakout stage, and captures 32 external status inputs for readback. Provides read/write, atomic set/clear, self-clearing pulse bits, synchronized input sampling, sticky rising-edge flags and a level interrupt. Sits between the CPU Wishbone interconnect and the per-peripheral breakout stages.

## Interface
- `RESET_VALUE`, 32'h0: reset value of the OUT register; bits also set in `PULSE_MASK` reset to 0.
- `PULSE_MASK`, 32'h0: OUT bits that self-clear one cycle after being written to 1.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `i_sig`; legal range 2–4.
- `i_clk`  in  1  single clock for all logic.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_wb_cyc`  in  1  bus cycle valid.
- `i_wb_stb`  in  1  strobe.
- `i_wb_we`  in  1  1 = write.
- `i_wb_adr`  in  3  word address.
- `i_wb_dat`  in  32  write data.
- `i_wb_sel`  in  4  byte enables; bit n covers data[8n+7:8n].
- `o_wb_dat`  out  32  read data, valid while `o_wb_ack` is high.
- `o_wb_ack`  out  1  transfer acknowledge.
- `o_bus`  out  32  OUT register, feeds the breakout stage.
- `i_sig`  in  32  asynchronous status inputs.
- `o_irq`  out  1  level interrupt, registered.

## Operation
- Register map (word address):
  - 0 OUT: R/W.
  - 1 SET: write ORs the data into OUT; reads return OUT.
  - 2 CLR: write clears the data bits in OUT; reads return OUT.
  - 3 IN: read-only, synchronized `i_sig`; writes ignored.
  - 4 EDGE: sticky rising-edge flags; write-1-to-clear.
  - 5 IEN: R/W interrupt enable mask.
  - 6–7: read 0, writes ignored.
- Byte enables apply to every write. Unselected bytes are untouched; for SET/CLR/EDGE they contribute zeros.
- Pulse bits: any OUT bit in `PULSE_MASK` written to 1 (via OUT or SET) is high on `o_bus` for exactly one cycle, then returns to 0 with no further access.
- Sync chain: `SYNC_STAGES` flops per bit, followed by a previous-value flop. An EDGE bit sets when synchronized=1 and previous=0.
- `o_irq` is registered: |(EDGE & IEN).
- Simultaneous events:
  - An edge detected in the same cycle as a W1C of that bit leaves the bit set (set wins).
  - A SET/CLR write on the same cycle as a pulse self-clear applies the write result.

## Timing
- Reset values: `o_bus`=RESET_VALUE & ~PULSE_MASK; `o_wb_ack`=0; `o_wb_dat`=0; EDGE=0; IEN=0; all sync and previous-value flops=0; `o_irq`=0.
- Handshake: when `i_wb_cyc & i_wb_stb & !o_wb_ack`, assert `o_wb_ack` for exactly one cycle on the next edge. `o_wb_ack` always drops the cycle after it is asserted. A held strobe therefore completes one transfer every 2 cycles.
- A write takes effect on the same edge that raises `o_wb_ack`; `o_bus` reflects it in that cycle.
- Read data is registered on the same edge as `o_wb_ack`. `o_wb_dat` returns to 0 when ack is low.
- If `i_wb_cyc` drops mid-request, no ack and no side effects.
- `i_sig` to IN-readable latency: `SYNC_STAGES` cycles.
- EDGE sets 1 cycle later; `o_irq` follows 1 cycle after that.
- `i_rst` asserted mid-transfer: ack and all state return to reset values on the next edge; the pending write is discarded.

## Test plan
- Reset with RESET_VALUE=32'hA5A5_0F0F, PULSE_MASK=32'h0000_0001 -> `o_bus`=32'hA5A5_0F0E; `o_wb_ack`, `o_irq`, EDGE, IEN all 0.
- Write OUT=32'h1234_5678 with sel=4'b0101, then SET 32'h8000_0000, then CLR 32'h0000_0078 -> read OUT returns 32'h8034_0000; each ack is one cycle wide, one cycle after strobe.
- Write SET 32'h0000_0001 with PULSE_MASK bit 0 -> `o_bus[0]` high exactly one cycle, then 0; the other bits are unchanged.
- Raise `i_sig[7]` with SYNC_STAGES=2 and IEN=32'h80 -> IN bit 7 readable after 2 cycles; EDGE=32'h80 one cycle later; `o_irq`=1 one cycle after that. W1C EDGE with 32'h80 -> `o_irq`=0 on the following cycle.
- Rising edge on `i_sig[3]` timed to land on the same cycle as a W1C of EDGE bit 3 -> EDGE bit 3 reads 1.
- Hold stb/cyc for 6 cycles -> exactly 3 acks, alternating; read of address 6 returns 0. Assert `i_rst` on the ack cycle of a write -> OUT shows RESET_VALUE & ~PULSE_MASK, not the written data.
